// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NR_REQ requesters.
// One transaction outstanding at a time; the grant is held until the response returns.
module mem_port_arbiter #(
    parameter int NR_REQ = 2,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NR_REQ-1:0]        i_req_valid,
    output logic [NR_REQ-1:0]        o_req_ready,
    input  logic [NR_REQ-1:0]        i_req_wen,
    input  logic [NR_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [NR_REQ*DATA_W-1:0] i_req_wdata,
    output logic                     o_mem_valid,
    input  logic                     i_mem_ready,
    output logic                     o_mem_wen,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [DATA_W-1:0]        o_mem_wdata,
    input  logic                     i_mem_rvalid,
    input  logic [DATA_W-1:0]        i_mem_rdata,
    output logic [NR_REQ-1:0]        o_rsp_valid,
    output logic [DATA_W-1:0]        o_rsp_data
);
    // state  | meaning
    // S_IDLE | no transaction; pick a winner among valid requesters
    // S_REQ  | request presented downstream, waiting for mem_ready
    // S_WAIT | request accepted downstream, waiting for mem_rvalid
    localparam int PW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_grant;
    logic              r_mem_valid;
    logic              r_mem_wen;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic [NR_REQ-1:0] w_win_oh;
    logic [PW-1:0]     w_win_idx;
    logic              w_any;
    logic              w_done;
    logic [PW-1:0]     w_ptr_nxt;
    logic              w_sel_wen;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // Search starts at r_ptr and wraps, so the last-served requester goes last.
    always_comb begin
        w_win_oh  = '0;
        w_win_idx = '0;
        w_any     = 1'b0;
        for (int i = 0; i < NR_REQ; i++) begin
            automatic int idx = (int'(r_ptr) + i) % NR_REQ;
            if (!w_any && i_req_valid[idx]) begin
                w_any         = 1'b1;
                w_win_idx     = PW'(idx);
                w_win_oh[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_wen   = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (w_win_oh[i]) begin
                w_sel_wen   = w_sel_wen | i_req_wen[i];
                w_sel_addr  = w_sel_addr | i_req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = w_sel_wdata | i_req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_done    = i_mem_rvalid &&
                       ((r_state == S_WAIT) || ((r_state == S_REQ) && i_mem_ready));
    assign w_ptr_nxt = (r_grant == PW'(NR_REQ - 1)) ? '0 : r_grant + 1'b1;

    assign o_req_ready = (r_state == S_IDLE) ? w_win_oh : '0;
    assign o_rsp_valid = w_done ? (NR_REQ'(1) << r_grant) : '0;
    assign o_rsp_data  = i_mem_rdata;
    assign o_mem_valid = r_mem_valid;
    assign o_mem_wen   = r_mem_wen;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_win_idx;
                        r_mem_valid <= 1'b1;
                        r_mem_wen   <= w_sel_wen;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_mem_ready) begin
                        r_mem_valid <= 1'b0;
                        if (i_mem_rvalid) begin
                            r_ptr   <= w_ptr_nxt;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_mem_rvalid) begin
                        r_ptr   <= w_ptr_nxt;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change after the falling edge,
// outputs are checked 1ns later, so every check sees one full cycle's values.
module tb_mem_port_arbiter;
    localparam int NR = 2;
    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid, req_ready, req_wen, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic            mem_valid, mem_ready, mem_wen, mem_rvalid;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata, mem_rdata, rsp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NR_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_wen(req_wen), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
        .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_wen(mem_wen),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
        .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_valid  = '0;
        req_wen    = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic do_reset();
        step();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        req_addr  = '0;
        req_wdata = '0;
        step();
        step();
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b exp 0", mem_valid); end
        checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_mem_wen got %b exp 0", mem_wen); end
        checks++; if (mem_addr !== 64'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 64'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        step();
        req_valid = 2'b01;
        req_addr[AW-1:0] = 64'h8000_0000;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rd_req_ready c0 got %b exp 01", req_ready); end
        step();
        req_valid = 2'b00;
        #1;
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rd_mem_valid c1 got %b exp 1", mem_valid); end
        checks++; if (mem_addr !== 64'h8000_0000) begin errors++; $display("FAIL rd_mem_addr got %h exp 80000000", mem_addr); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rd_req_ready c1 got %b exp 00", req_ready); end
        step();
        mem_ready = 1'b1;
        #1;
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL rd_mem_valid c2 got %b exp 1", mem_valid); end
        step();
        mem_ready = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rd_mem_valid c3 got %b exp 0", mem_valid); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_rsp_early c3 got %b exp 00", rsp_valid); end
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD_BEEF;
        #1;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rd_rsp_valid c4 got %b exp 01", rsp_valid); end
        checks++; if (rsp_data !== 64'hDEAD_BEEF) begin errors++; $display("FAIL rd_rsp_data got %h exp deadbeef", rsp_data); end
        step();
        clear_inputs();
        #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_rsp_valid c5 got %b exp 00", rsp_valid); end
    endtask

    task automatic test_contention();
        logic [1:0]  exp_oh;
        logic [63:0] exp_addr;
        do_reset();
        step();
        req_valid = 2'b11;
        req_addr  = {64'h200, 64'h100};
        mem_ready = 1'b1;
        mem_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_oh   = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (k % 2 == 0) ? 64'h100 : 64'h200;
            mem_rdata = 64'h1000 + 64'(k);
            #1;
            checks++; if (req_ready !== exp_oh) begin errors++; $display("FAIL cont_grant k=%0d got %b exp %b", k, req_ready, exp_oh); end
            checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL cont_idle_rsp k=%0d got %b exp 00", k, rsp_valid); end
            step();
            #1;
            checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL cont_addr k=%0d got %h exp %h", k, mem_addr, exp_addr); end
            checks++; if (rsp_valid !== exp_oh) begin errors++; $display("FAIL cont_rsp k=%0d got %b exp %b", k, rsp_valid, exp_oh); end
            checks++; if (rsp_data !== 64'h1000 + 64'(k)) begin errors++; $display("FAIL cont_data k=%0d got %h exp %h", k, rsp_data, 64'h1000 + 64'(k)); end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_write_ack();
        step();
        req_valid = 2'b10;
        req_wen   = 2'b10;
        req_addr[2*AW-1:AW]  = 64'h8000_1000;
        req_wdata[2*DW-1:DW] = 64'h1234;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL wr_req_ready got %b exp 10", req_ready); end
        step();
        req_valid = 2'b00;
        req_wen   = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL wr_hold_valid c=%0d got %b exp 1", c, mem_valid); end
            checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL wr_hold_wen c=%0d got %b exp 1", c, mem_wen); end
            checks++; if (mem_addr !== 64'h8000_1000) begin errors++; $display("FAIL wr_hold_addr c=%0d got %h exp 80001000", c, mem_addr); end
            checks++; if (mem_wdata !== 64'h1234) begin errors++; $display("FAIL wr_hold_wdata c=%0d got %h exp 1234", c, mem_wdata); end
            step();
        end
        mem_ready = 1'b1;
        #1;
        checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL wr_accept_valid got %b exp 1", mem_valid); end
        step();
        mem_ready = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL wr_wait_valid got %b exp 0", mem_valid); end
        step();
        mem_rvalid = 1'b1;
        #1;
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL wr_ack_rsp got %b exp 10", rsp_valid); end
        step();
        clear_inputs();
    endtask

    task automatic test_same_cycle();
        step();
        req_valid = 2'b01;
        req_addr  = {64'hB000, 64'hA000};
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL sc_grant0 got %b exp 01", req_ready); end
        step();
        req_valid  = 2'b00;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hABC;
        #1;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL sc_rsp0 got %b exp 01", rsp_valid); end
        checks++; if (rsp_data !== 64'hABC) begin errors++; $display("FAIL sc_data got %h exp abc", rsp_data); end
        step();
        clear_inputs();
        req_valid = 2'b10;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL sc_regrant got %b exp 10", req_ready); end
        step();
        req_valid  = 2'b00;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        #1;
        checks++; if (mem_addr !== 64'hB000) begin errors++; $display("FAIL sc_addr1 got %h exp b000", mem_addr); end
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL sc_rsp1 got %b exp 10", rsp_valid); end
        step();
        clear_inputs();
    endtask

    task automatic test_stray_rvalid();
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h55;
        #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL stray_rsp got %b exp 00", rsp_valid); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL stray_ready got %b exp 00", req_ready); end
        step();
        clear_inputs();
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stray_ptr got %b exp 01", req_ready); end
        step();
        req_valid  = 2'b00;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        #1;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL stray_done got %b exp 01", rsp_valid); end
        step();
        clear_inputs();
    endtask

    task automatic test_reset_in_wait();
        step();
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rw_grant1 got %b exp 10", req_ready); end
        step();
        req_valid = 2'b00;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rw_wait_valid got %b exp 0", mem_valid); end
        step();
        rst = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rw_post_valid got %b exp 0", mem_valid); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rw_post_rsp got %b exp 00", rsp_valid); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rw_post_ready got %b exp 00", req_ready); end
        step();
        mem_rvalid = 1'b0;
        req_valid  = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rw_regrant got %b exp 01", req_ready); end
        step();
        req_valid  = 2'b00;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        #1;
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rw_done got %b exp 01", rsp_valid); end
        step();
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write_ack();
        test_same_cycle();
        test_stray_rvalid();
        test_reset_in_wait();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
